// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with programmable almost-full/almost-empty thresholds,
// fill count, sticky overflow/underflow flags, synchronous flush and a standard or FWFT read port.
module sync_fifo_param #(
    parameter  int DATA_SIZE = 8,
    parameter  int DEPTH     = 16,
    parameter  int AF_LEVEL  = 14,
    parameter  int AE_LEVEL  = 2,
    parameter  int FWFT      = 0,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 wr_full,
    output logic                 rd_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_W:0]      count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C       = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C       = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] PTR_ONE    = (ADDR_W+1)'(1);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];

    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [ADDR_W:0] r_count;
    logic            r_full;
    logic            r_empty;
    logic            r_almost_full;
    logic            r_almost_empty;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [ADDR_W:0] w_wr_ptr_nxt;
    logic [ADDR_W:0] w_rd_ptr_nxt;
    logic [ADDR_W:0] w_count_nxt;

    // Accept decisions use only the registered flags, so a full FIFO can still pop
    // and an empty FIFO can still push in the same cycle.
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    // NOTE: combinational next-state logic uses blocking '=' with a default first, so no latch is inferred.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_wr_acc) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
        end
        if (w_rd_acc) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
        end
        if (clr) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end
    end

    // The extra wrap bit makes the pointer difference the exact fill level, 0..DEPTH.
    assign w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == DEPTH_C);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= AF_C);
            r_almost_empty <= (w_count_nxt <= AE_C);
            if (clr) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (wr_en && r_full) begin
                    r_overflow <= 1'b1;
                end
                if (rd_en && r_empty) begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

    // NOTE: the storage array has no reset; only pointers and flags define its contents as valid.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !clr) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is presented directly; forced to zero while empty so the
            // port never shows stale or uninitialised storage.
            assign rd_data  = r_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
            assign rd_valid = ~r_empty;
        end else begin : g_std
            logic [DATA_SIZE-1:0] r_rd_data;
            logic                 r_rd_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (clr) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
                    end
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign wr_full      = r_full;
    assign rd_empty     = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one standard-read and one FWFT instance share the same stimulus
// and are compared every cycle against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 14;
    localparam int AE     = 2;
    localparam int ADDR_W = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic [DW-1:0]   s_rd_data, f_rd_data;
    logic            s_rd_valid, f_rd_valid;
    logic            s_full, f_full, s_empty, f_empty;
    logic            s_af, f_af, s_ae, f_ae;
    logic [ADDR_W:0] s_count, f_count;
    logic            s_ovf, f_ovf, s_unf, f_unf;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_std_data;
    logic          exp_std_valid;
    logic          exp_ovf;
    logic          exp_unf;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_SIZE(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .wr_full(s_full), .rd_empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_param #(.DATA_SIZE(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .wr_full(f_full), .rd_empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_std_data  = '0;
        exp_std_valid = 1'b0;
        exp_ovf       = 1'b0;
        exp_unf       = 1'b0;
    endtask

    task automatic check_all(input string ph);
        int n;
        n = model_q.size();
        check({ph, ".s_count"}, 32'(s_count), 32'(n));
        check({ph, ".f_count"}, 32'(f_count), 32'(n));
        check({ph, ".s_full"},  32'(s_full),  32'(n == DEPTH));
        check({ph, ".f_full"},  32'(f_full),  32'(n == DEPTH));
        check({ph, ".s_empty"}, 32'(s_empty), 32'(n == 0));
        check({ph, ".f_empty"}, 32'(f_empty), 32'(n == 0));
        check({ph, ".s_af"},    32'(s_af),    32'(n >= AF));
        check({ph, ".f_af"},    32'(f_af),    32'(n >= AF));
        check({ph, ".s_ae"},    32'(s_ae),    32'(n <= AE));
        check({ph, ".f_ae"},    32'(f_ae),    32'(n <= AE));
        check({ph, ".s_ovf"},   32'(s_ovf),   32'(exp_ovf));
        check({ph, ".f_ovf"},   32'(f_ovf),   32'(exp_ovf));
        check({ph, ".s_unf"},   32'(s_unf),   32'(exp_unf));
        check({ph, ".f_unf"},   32'(f_unf),   32'(exp_unf));
        check({ph, ".s_valid"}, 32'(s_rd_valid), 32'(exp_std_valid));
        check({ph, ".s_data"},  32'(s_rd_data),  32'(exp_std_data));
        check({ph, ".f_valid"}, 32'(f_rd_valid), 32'(n != 0));
        if (n != 0)
            check({ph, ".f_data"}, 32'(f_rd_data), 32'(model_q[0]));
    endtask

    // One clock edge with the currently driven inputs; the model decides acceptance
    // from its pre-edge fill level, then both DUTs are compared 1 ns after the edge.
    task automatic tick(input string ph);
        bit full, empty, wacc, racc;
        full  = (model_q.size() == DEPTH);
        empty = (model_q.size() == 0);
        wacc  = wr_en && !full;
        racc  = rd_en && !empty;
        @(posedge clk);
        if (clr) begin
            model_q.delete();
            exp_ovf       = 1'b0;
            exp_unf       = 1'b0;
            exp_std_valid = 1'b0;
        end else begin
            exp_std_valid = racc;
            if (racc) exp_std_data = model_q.pop_front();
            if (wacc) model_q.push_back(wr_data);
            if (wr_en && full)  exp_ovf = 1'b1;
            if (rd_en && empty) exp_unf = 1'b1;
        end
        #1;
        check_all(ph);
    endtask

    task automatic drive(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        clr     = c;
    endtask

    // Asynchronous reset: outputs must reach reset values before any clock edge.
    task automatic do_reset(input string ph);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(ph);
        @(posedge clk);
        #1;
        check_all(ph);
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        #1;
        do_reset("rst0");

        // Fill 0x01..0x10, then one rejected write, then drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, 0, DW'(i), 0);
            tick("fill");
        end
        check("fill.af_at_full", 32'(s_af), 32'd1);
        drive(1, 0, 8'hEE, 0);
        tick("fill.over");
        check("fill.overflow", 32'(s_ovf), 32'd1);
        check("fill.count16",  32'(s_count), 32'd16);
        for (int i = 1; i <= DEPTH; i++) begin
            drive(0, 1, '0, 0);
            tick("drain");
            check("drain.order", 32'(s_rd_data), 32'(i));
        end
        drive(0, 0, '0, 0);
        tick("drain.end");
        check("drain.empty", 32'(s_empty), 32'd1);

        // Simultaneous read and write at count 8 across pointer wrap.
        drive(0, 0, '0, 1);
        tick("clr");
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, DW'(8'h40 + i), 0);
            tick("sim.pre");
        end
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, DW'(8'h80 + i), 0);
            tick("sim.mid");
        end
        check("sim.count8", 32'(f_count), 32'd8);

        // Simultaneous at full: read wins, write rejected.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, DW'(8'hC0 + i), 0);
            tick("sim.fill");
        end
        drive(1, 1, 8'hFF, 0);
        tick("sim.full");
        check("sim.full.count15", 32'(s_count), 32'd15);
        check("sim.full.ovf",     32'(s_ovf), 32'd1);

        // Simultaneous at empty: write wins, read rejected.
        drive(0, 0, '0, 1);
        tick("clr2");
        drive(1, 1, 8'h3C, 0);
        tick("sim.empty");
        check("sim.empty.count1", 32'(s_count), 32'd1);
        check("sim.empty.unf",    32'(s_unf), 32'd1);

        // Latency: 0xA5 into an empty FIFO.
        drive(0, 0, '0, 1);
        tick("clr3");
        drive(1, 0, 8'hA5, 0);
        tick("lat.wr");
        check("lat.s_empty_low", 32'(s_empty), 32'd0);
        check("lat.f_data",      32'(f_rd_data), 32'hA5);
        check("lat.f_valid",     32'(f_rd_valid), 32'd1);
        drive(0, 1, '0, 0);
        tick("lat.rd");
        check("lat.s_data",  32'(s_rd_data), 32'hA5);
        check("lat.s_valid", 32'(s_rd_valid), 32'd1);
        drive(0, 0, '0, 0);
        tick("lat.idle");
        check("lat.s_valid_drop", 32'(s_rd_valid), 32'd0);

        // Flush at count 9 with overflow set; the concurrent write is discarded.
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1, 0, DW'(8'h10 + i), 0);
            tick("fl.fill");
        end
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, '0, 0);
            tick("fl.rd");
        end
        check("fl.count9", 32'(s_count), 32'd9);
        drive(1, 0, 8'h77, 1);
        tick("fl.clr");
        check("fl.count0", 32'(s_count), 32'd0);
        check("fl.empty",  32'(f_empty), 32'd1);
        check("fl.ovf0",   32'(f_ovf), 32'd0);

        // Mid-stream reset at count 5.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, DW'(8'h50 + i), 0);
            tick("mr.fill");
        end
        drive(1, 1, 8'h99, 0);
        do_reset("mr.rst");
        check("mr.count0", 32'(s_count), 32'd0);

        // Random traffic with phases biased toward filling, draining and balanced.
        for (int i = 0; i < 10000; i++) begin
            int pw, pr;
            case ((i / 500) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 25; pr = 80; end
                default: begin pw = 55; pr = 55; end
            endcase
            d = DW'($urandom);
            drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, d,
                  $urandom_range(0, 799) == 0);
            tick("rand");
        end

        drive(0, 0, '0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
